tarb_unit: RTL and testbench
============================

# tarb_unit

Traversal arbiter in front of the tree cache (tcache). It merges three request streams into the single tcache request port: new rays from raygen, descend requests from trav_unit, and restart/pop requests from the short stack (ss). Merged requests are registered with one-cycle latency, and the block enforces a ray-occupancy limit so the traversal loop cannot deadlock. In-flight traffic (trav, ss) always has priority over new rays. Admission of new rays is throttled by an in-flight credit counter, which is decremented by ray retirement.

## Interface
Parameters:
- MAX_RAYS, default 64: maximum rays resident in the traversal loop.
- CNT_W, default $clog2(MAX_RAYS+1) = 7: width of the occupancy counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous and active-low (asserted when 0).
- raygen_to_tarb_valid  in  1  new-ray request valid.
- raygen_to_tarb_data  in  $bits(tarb_t)  new-ray request.
- raygen_to_tarb_stall  out  1  new-ray request not accepted this cycle.
- trav_to_tarb_valid  in  1  trav descend request valid.
- trav_to_tarb_data  in  $bits(tarb_t)  trav descend request.
- trav_to_tarb_stall  out  1  trav descend request not accepted.
- ss_to_tarb_valid  in  1  stack pop/restart request valid.
- ss_to_tarb_data  in  $bits(tarb_t)  stack pop/restart request.
- ss_to_tarb_stall  out  1  stack request not accepted.
- tarb_to_tcache_valid  out  1  merged request valid (registered).
- tarb_to_tcache_data  out  $bits(tarb_t)  merged request (registered).
- tarb_to_tcache_stall  in  1  tcache back-pressure.
- ray_retire  in  1  single-cycle pulse; one ray has left the loop (hit list / miss).
- rays_in_flight  out  CNT_W  current occupancy (registered).
- err_underflow  out  1  sticky flag: a retire pulse arrived while the count was 0.

## Operation
- Handshake on every port: a transfer occurs at a posedge where valid=1 and stall=0. A source holds valid and data stable while stalled.
- ready flop: reset to 0, set to 1 on the first posedge after reset deasserts. While ready=0, all three input stalls are 1.
- load_en = ready & (~tarb_to_tcache_valid | ~tarb_to_tcache_stall).
- Class A arbitration (trav, ss): round-robin pointer rr.
  - rr=0 prefers trav, rr=1 prefers ss.
  - If only one class A input is valid, that input wins.
  - rr advances to point at the loser only when a class A grant transfers (grant & load_en).
- Class B (raygen) is granted only when both class A valids are 0 and rays_in_flight < MAX_RAYS, using the registered count.
- At most one grant per cycle. The granted input has stall = ~load_en; every other input has stall = 1. Stall outputs are combinational from the valids and registered state.
- Output register: on load_en with a grant, data ← granted data and valid ← 1. On load_en with no grant, valid ← 0. When load_en=0 (output valid and stalled), the register holds.
- Counter: count_next = count + admit − retire.
  - admit = raygen transfer.
  - retire = ray_retire & (count≠0 | admit).
  - Admit and retire in the same cycle leave the count unchanged.
  - A retire pulse with count=0 and no admit is dropped and sets err_underflow.
- Class A requests never change the count; they carry rays already resident.

## Timing
- Reset values: tarb_to_tcache_valid=0, tarb_to_tcache_data=0, rays_in_flight=0, err_underflow=0, rr=0, ready=0, all input stalls=1.
- Latency from input transfer to tarb_to_tcache_valid is 1 cycle.
- Throughput is one request per cycle when the tcache does not stall.
- tcache stall propagates to the input stalls combinationally in the same cycle; no internal data is lost.
- rays_in_flight reflects an admit or retire one cycle after the event.
- Once rays_in_flight = MAX_RAYS, raygen stall stays 1 until a retire is registered. Raygen can transfer again the cycle after the retire is registered.
- Asynchronous reset mid-transfer clears the output register. The in-flight request is discarded, and the sources observe stall=1 until ready=1.
- err_underflow is cleared only by reset.

## Test plan
- Reset, then single raygen request (rayID 2, nodeID 0), no stall -> tcache valid 1 cycle later with identical data; rays_in_flight=1; raygen stall=0 in the transfer cycle.
- trav and ss both valid continuously for 6 cycles -> grants alternate trav, ss, trav, ss, trav, ss; raygen held valid throughout sees stall=1 all 6 cycles.
- MAX_RAYS=4: raygen valid for 8 cycles with no retire -> exactly 4 transfers, count=4, stall=1 thereafter; one ray_retire pulse -> count=3 the next cycle, then one more transfer -> count=4.
- tcache stall=1 for 3 cycles while trav is valid -> output data held, trav stall=1 for 3 cycles; after release, the held request is consumed and trav transfers the next cycle.
- raygen admit and ray_retire in the same cycle with count=2 -> count stays 2; ray_retire with count=0 -> count 0, err_underflow=1 and sticky.
- Assert rst (0) while the output is valid and stalled -> valid=0, count=0 immediately; first input transfer is possible on the second posedge after release.

Source files
------------

// File: rtl/tarb_unit.sv
// Traversal arbiter: merges trav, short-stack and raygen requests into one registered tcache
// request stream. In-flight traffic wins over new rays, which are throttled by an occupancy count.
module tarb_unit #(
  parameter int unsigned MAX_RAYS = 64,
  parameter int unsigned CNT_W    = $clog2(MAX_RAYS + 1),
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              raygen_to_tarb_valid,
  input  logic [DATA_W-1:0] raygen_to_tarb_data,
  output logic              raygen_to_tarb_stall,

  input  logic              trav_to_tarb_valid,
  input  logic [DATA_W-1:0] trav_to_tarb_data,
  output logic              trav_to_tarb_stall,

  input  logic              ss_to_tarb_valid,
  input  logic [DATA_W-1:0] ss_to_tarb_data,
  output logic              ss_to_tarb_stall,

  output logic              tarb_to_tcache_valid,
  output logic [DATA_W-1:0] tarb_to_tcache_data,
  input  logic              tarb_to_tcache_stall,

  input  logic              ray_retire,
  output logic [CNT_W-1:0]  rays_in_flight,
  output logic              err_underflow
);

  logic              ready_q;
  logic              rr_q, rr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic load_en;
  logic gnt_trav, gnt_ss, gnt_ray, any_gnt;
  logic admit, retire;

  assign load_en = ready_q & (~out_valid_q | ~tarb_to_tcache_stall);

  // rr_q=0 prefers trav, rr_q=1 prefers ss; raygen only when no class A traffic and below limit
  assign gnt_trav = trav_to_tarb_valid & (~ss_to_tarb_valid | ~rr_q);
  assign gnt_ss   = ss_to_tarb_valid & (~trav_to_tarb_valid | rr_q);
  assign gnt_ray  = raygen_to_tarb_valid & ~trav_to_tarb_valid & ~ss_to_tarb_valid &
                    (count_q < CNT_W'(MAX_RAYS));
  assign any_gnt  = gnt_trav | gnt_ss | gnt_ray;

  assign trav_to_tarb_stall   = ~(gnt_trav & load_en);
  assign ss_to_tarb_stall     = ~(gnt_ss & load_en);
  assign raygen_to_tarb_stall = ~(gnt_ray & load_en);

  assign admit  = gnt_ray & load_en;
  assign retire = ray_retire & ((count_q != '0) | admit);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_d        = rr_q;
    if (load_en) begin
      out_valid_d = any_gnt;
      if (gnt_trav) begin
        out_data_d = trav_to_tarb_data;
        rr_d       = 1'b1;
      end else if (gnt_ss) begin
        out_data_d = ss_to_tarb_data;
        rr_d       = 1'b0;
      end else if (gnt_ray) begin
        out_data_d = raygen_to_tarb_data;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (admit && !retire) begin
      count_d = count_q + CNT_W'(1);
    end else if (retire && !admit) begin
      count_d = count_q - CNT_W'(1);
    end
    err_d = err_q | (ray_retire & ~admit & (count_q == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q     <= 1'b0;
      rr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      ready_q     <= 1'b1;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign tarb_to_tcache_valid = out_valid_q;
  assign tarb_to_tcache_data  = out_data_q;
  assign rays_in_flight       = count_q;
  assign err_underflow        = err_q;

endmodule

// File: tb/tb_tarb_unit.sv
// Directed scenarios plus a randomized run against a transaction-level model of tarb_unit.
module tb_tarb_unit;
  localparam int unsigned MaxRays = 4;
  localparam int unsigned CntW    = 3;
  localparam int unsigned DW      = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          raygen_to_tarb_valid, raygen_to_tarb_stall;
  logic [DW-1:0] raygen_to_tarb_data;
  logic          trav_to_tarb_valid, trav_to_tarb_stall;
  logic [DW-1:0] trav_to_tarb_data;
  logic          ss_to_tarb_valid, ss_to_tarb_stall;
  logic [DW-1:0] ss_to_tarb_data;
  logic          tarb_to_tcache_valid, tarb_to_tcache_stall;
  logic [DW-1:0] tarb_to_tcache_data;
  logic          ray_retire;
  logic [CntW-1:0] rays_in_flight;
  logic          err_underflow;

  int n_checks = 0;
  int n_errors = 0;

  tarb_unit #(.MAX_RAYS(MaxRays), .CNT_W(CntW), .DATA_W(DW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .raygen_to_tarb_valid (raygen_to_tarb_valid),
    .raygen_to_tarb_data  (raygen_to_tarb_data),
    .raygen_to_tarb_stall (raygen_to_tarb_stall),
    .trav_to_tarb_valid   (trav_to_tarb_valid),
    .trav_to_tarb_data    (trav_to_tarb_data),
    .trav_to_tarb_stall   (trav_to_tarb_stall),
    .ss_to_tarb_valid     (ss_to_tarb_valid),
    .ss_to_tarb_data      (ss_to_tarb_data),
    .ss_to_tarb_stall     (ss_to_tarb_stall),
    .tarb_to_tcache_valid (tarb_to_tcache_valid),
    .tarb_to_tcache_data  (tarb_to_tcache_data),
    .tarb_to_tcache_stall (tarb_to_tcache_stall),
    .ray_retire           (ray_retire),
    .rays_in_flight       (rays_in_flight),
    .err_underflow        (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    raygen_to_tarb_valid = 1'b0;
    trav_to_tarb_valid   = 1'b0;
    ss_to_tarb_valid     = 1'b0;
    tarb_to_tcache_stall = 1'b0;
    ray_retire           = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    raygen_to_tarb_data = '0;
    trav_to_tarb_data   = '0;
    ss_to_tarb_data     = '0;
    #2;
    raygen_to_tarb_valid = 1'b1;
    trav_to_tarb_valid   = 1'b1;
    ss_to_tarb_valid     = 1'b1;
    #1;
    n_checks++;
    if (tarb_to_tcache_valid !== 1'b0 || tarb_to_tcache_data !== '0) begin
      n_errors++;
      $display("FAIL reset_out: valid=%b data=%h expected 0/0", tarb_to_tcache_valid,
               tarb_to_tcache_data);
    end
    n_checks++;
    if (rays_in_flight !== '0 || err_underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_cnt: count=%0d err=%b expected 0/0", rays_in_flight, err_underflow);
    end
    n_checks++;
    if ({raygen_to_tarb_stall, trav_to_tarb_stall, ss_to_tarb_stall} !== 3'b111) begin
      n_errors++;
      $display("FAIL reset_stall: got %b expected 111",
               {raygen_to_tarb_stall, trav_to_tarb_stall, ss_to_tarb_stall});
    end
    tick();
    trav_to_tarb_valid = 1'b0;
    ss_to_tarb_valid   = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (raygen_to_tarb_stall !== 1'b1) begin
      n_errors++;
      $display("FAIL not_ready_stall: got %b expected 1", raygen_to_tarb_stall);
    end
    tick();
    raygen_to_tarb_valid = 1'b0;
    tick();
    n_checks++;
    if (tarb_to_tcache_valid !== 1'b0 || rays_in_flight !== '0) begin
      n_errors++;
      $display("FAIL no_xfer_before_ready: valid=%b count=%0d expected 0/0",
               tarb_to_tcache_valid, rays_in_flight);
    end
  endtask

  task automatic test_single_raygen();
    raygen_to_tarb_valid = 1'b1;
    raygen_to_tarb_data  = 32'h0002_0000;
    #1;
    n_checks++;
    if (raygen_to_tarb_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL single_stall: got %b expected 0", raygen_to_tarb_stall);
    end
    tick();
    raygen_to_tarb_valid = 1'b0;
    n_checks++;
    if (tarb_to_tcache_valid !== 1'b1 || tarb_to_tcache_data !== 32'h0002_0000) begin
      n_errors++;
      $display("FAIL single_out: valid=%b data=%h expected 1/00020000", tarb_to_tcache_valid,
               tarb_to_tcache_data);
    end
    n_checks++;
    if (rays_in_flight !== CntW'(1)) begin
      n_errors++;
      $display("FAIL single_count: got %0d expected 1", rays_in_flight);
    end
    tick();
    n_checks++;
    if (tarb_to_tcache_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_drain: got %b expected 0", tarb_to_tcache_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_data;
    trav_to_tarb_valid   = 1'b1;
    trav_to_tarb_data    = 32'hA000_0001;
    ss_to_tarb_valid     = 1'b1;
    ss_to_tarb_data      = 32'hB000_0002;
    raygen_to_tarb_valid = 1'b1;
    raygen_to_tarb_data  = 32'hC000_0003;
    for (int i = 0; i < 6; i++) begin
      logic want_trav;
      want_trav = (i % 2 == 0);
      exp_data  = want_trav ? trav_to_tarb_data : ss_to_tarb_data;
      #1;
      n_checks++;
      if ({raygen_to_tarb_stall, trav_to_tarb_stall, ss_to_tarb_stall} !==
          {1'b1, ~want_trav, want_trav}) begin
        n_errors++;
        $display("FAIL rr_stall[%0d]: got %b expected %b", i,
                 {raygen_to_tarb_stall, trav_to_tarb_stall, ss_to_tarb_stall},
                 {1'b1, ~want_trav, want_trav});
      end
      tick();
      n_checks++;
      if (tarb_to_tcache_data !== exp_data) begin
        n_errors++;
        $display("FAIL rr_data[%0d]: got %h expected %h", i, tarb_to_tcache_data, exp_data);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_ray_limit();
    int n_xfer = 0;
    ray_retire = 1'b1;
    tick();
    ray_retire = 1'b0;
    n_checks++;
    if (rays_in_flight !== '0) begin
      n_errors++;
      $display("FAIL limit_pre: count=%0d expected 0", rays_in_flight);
    end
    raygen_to_tarb_valid = 1'b1;
    raygen_to_tarb_data  = 32'h0001_0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (raygen_to_tarb_stall === 1'b0) n_xfer++;
      tick();
    end
    #1;
    n_checks++;
    if (n_xfer != MaxRays || rays_in_flight !== CntW'(MaxRays) || raygen_to_tarb_stall !== 1'b1)
    begin
      n_errors++;
      $display("FAIL limit_fill: xfers=%0d count=%0d stall=%b expected 4/4/1", n_xfer,
               rays_in_flight, raygen_to_tarb_stall);
    end
    ray_retire = 1'b1;
    tick();
    ray_retire = 1'b0;
    n_checks++;
    if (rays_in_flight !== CntW'(3)) begin
      n_errors++;
      $display("FAIL limit_retire: count=%0d expected 3", rays_in_flight);
    end
    #1;
    n_checks++;
    if (raygen_to_tarb_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL limit_reopen: stall=%b expected 0", raygen_to_tarb_stall);
    end
    tick();
    #1;
    n_checks++;
    if (rays_in_flight !== CntW'(4) || raygen_to_tarb_stall !== 1'b1) begin
      n_errors++;
      $display("FAIL limit_refill: count=%0d stall=%b expected 4/1", rays_in_flight,
               raygen_to_tarb_stall);
    end
    raygen_to_tarb_valid = 1'b0;
    tick();
  endtask

  task automatic test_tcache_stall();
    trav_to_tarb_valid   = 1'b1;
    trav_to_tarb_data    = 32'h0003_0005;
    tarb_to_tcache_stall = 1'b1;
    #1;
    n_checks++;
    if (trav_to_tarb_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_first: stall=%b expected 0", trav_to_tarb_stall);
    end
    tick();
    trav_to_tarb_data = 32'h0004_0006;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (trav_to_tarb_stall !== 1'b1) begin
        n_errors++;
        $display("FAIL bp_stall[%0d]: stall=%b expected 1", i, trav_to_tarb_stall);
      end
      tick();
      n_checks++;
      if (tarb_to_tcache_valid !== 1'b1 || tarb_to_tcache_data !== 32'h0003_0005) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h expected 1/00030005", i,
                 tarb_to_tcache_valid, tarb_to_tcache_data);
      end
    end
    tarb_to_tcache_stall = 1'b0;
    #1;
    n_checks++;
    if (trav_to_tarb_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_release: stall=%b expected 0", trav_to_tarb_stall);
    end
    tick();
    trav_to_tarb_valid = 1'b0;
    n_checks++;
    if (tarb_to_tcache_valid !== 1'b1 || tarb_to_tcache_data !== 32'h0004_0006) begin
      n_errors++;
      $display("FAIL bp_next: valid=%b data=%h expected 1/00040006", tarb_to_tcache_valid,
               tarb_to_tcache_data);
    end
    tick();
  endtask

  task automatic test_admit_retire();
    ray_retire = 1'b1;
    tick();
    tick();
    ray_retire = 1'b0;
    n_checks++;
    if (rays_in_flight !== CntW'(2)) begin
      n_errors++;
      $display("FAIL ar_pre: count=%0d expected 2", rays_in_flight);
    end
    raygen_to_tarb_valid = 1'b1;
    ray_retire           = 1'b1;
    #1;
    n_checks++;
    if (raygen_to_tarb_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_stall: stall=%b expected 0", raygen_to_tarb_stall);
    end
    tick();
    raygen_to_tarb_valid = 1'b0;
    n_checks++;
    if (rays_in_flight !== CntW'(2) || err_underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_same: count=%0d err=%b expected 2/0", rays_in_flight, err_underflow);
    end
    tick();
    tick();
    n_checks++;
    if (rays_in_flight !== '0 || err_underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_zero: count=%0d err=%b expected 0/0", rays_in_flight, err_underflow);
    end
    tick();
    ray_retire = 1'b0;
    n_checks++;
    if (rays_in_flight !== '0 || err_underflow !== 1'b1) begin
      n_errors++;
      $display("FAIL underflow: count=%0d err=%b expected 0/1", rays_in_flight, err_underflow);
    end
    tick();
    tick();
    n_checks++;
    if (err_underflow !== 1'b1) begin
      n_errors++;
      $display("FAIL underflow_sticky: err=%b expected 1", err_underflow);
    end
  endtask

  task automatic test_async_reset();
    raygen_to_tarb_valid = 1'b1;
    raygen_to_tarb_data  = 32'h0007_0000;
    tick();
    raygen_to_tarb_valid = 1'b0;
    trav_to_tarb_valid   = 1'b1;
    trav_to_tarb_data    = 32'h0008_0009;
    tarb_to_tcache_stall = 1'b1;
    tick();
    n_checks++;
    if (tarb_to_tcache_valid !== 1'b1 || rays_in_flight !== CntW'(1)) begin
      n_errors++;
      $display("FAIL arst_pre: valid=%b count=%0d expected 1/1", tarb_to_tcache_valid,
               rays_in_flight);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (tarb_to_tcache_valid !== 1'b0 || rays_in_flight !== '0 || err_underflow !== 1'b0 ||
        trav_to_tarb_stall !== 1'b1) begin
      n_errors++;
      $display("FAIL arst_clear: valid=%b count=%0d err=%b stall=%b expected 0/0/0/1",
               tarb_to_tcache_valid, rays_in_flight, err_underflow, trav_to_tarb_stall);
    end
    tarb_to_tcache_stall = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (trav_to_tarb_stall !== 1'b1) begin
      n_errors++;
      $display("FAIL arst_not_ready: stall=%b expected 1", trav_to_tarb_stall);
    end
    tick();
    n_checks++;
    if (tarb_to_tcache_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL arst_first_edge: valid=%b expected 0", tarb_to_tcache_valid);
    end
    #1;
    n_checks++;
    if (trav_to_tarb_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL arst_ready: stall=%b expected 0", trav_to_tarb_stall);
    end
    tick();
    trav_to_tarb_valid = 1'b0;
    n_checks++;
    if (tarb_to_tcache_valid !== 1'b1 || tarb_to_tcache_data !== 32'h0008_0009) begin
      n_errors++;
      $display("FAIL arst_second_edge: valid=%b data=%h expected 1/00080009",
               tarb_to_tcache_valid, tarb_to_tcache_data);
    end
    tick();
  endtask

  // Reference model: sources 0=raygen, 1=trav, 2=ss; class A alternates fairly, raygen fills gaps.
  task automatic test_random();
    int            m_count = 0;
    int            m_next_a = 1;
    bit            m_out_valid = 1'b0;
    logic [DW-1:0] m_out_data = '0;
    bit            m_err = 1'b0;
    bit            v[3] = '{1'b0, 1'b0, 1'b0};
    logic [DW-1:0] d[3];
    bit            exp_stall[3] = '{1'b1, 1'b1, 1'b1};
    idle_inputs();
    rst = 1'b0;
    #3 rst = 1'b1;
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int win;
      bit can_load, tstall, retire_in, admit;
      for (int s = 0; s < 3; s++) begin
        if (!(v[s] && exp_stall[s])) begin
          v[s] = ($urandom_range(0, 99) < (s == 0 ? 70 : 35));
          d[s] = $urandom;
        end
      end
      tstall    = ($urandom_range(0, 99) < 25);
      retire_in = ($urandom_range(0, 99) < 30);
      raygen_to_tarb_valid = v[0];
      raygen_to_tarb_data  = d[0];
      trav_to_tarb_valid   = v[1];
      trav_to_tarb_data    = d[1];
      ss_to_tarb_valid     = v[2];
      ss_to_tarb_data      = d[2];
      tarb_to_tcache_stall = tstall;
      ray_retire           = retire_in;

      if (v[1] && v[2]) win = m_next_a;
      else if (v[1]) win = 1;
      else if (v[2]) win = 2;
      else if (v[0] && m_count < int'(MaxRays)) win = 0;
      else win = -1;
      can_load = !m_out_valid || !tstall;
      for (int s = 0; s < 3; s++) exp_stall[s] = !(can_load && win == s);

      #1;
      n_checks++;
      if ({raygen_to_tarb_stall, trav_to_tarb_stall, ss_to_tarb_stall} !==
          {exp_stall[0], exp_stall[1], exp_stall[2]}) begin
        n_errors++;
        $display("FAIL rand_stall[%0d]: got %b expected %b", cyc,
                 {raygen_to_tarb_stall, trav_to_tarb_stall, ss_to_tarb_stall},
                 {exp_stall[0], exp_stall[1], exp_stall[2]});
      end
      tick();

      admit = can_load && win == 0;
      if (can_load) begin
        m_out_valid = (win >= 0);
        if (win >= 0) m_out_data = d[win];
        if (win == 1) m_next_a = 2;
        if (win == 2) m_next_a = 1;
      end
      if (admit) m_count++;
      if (retire_in) begin
        if (m_count > 0) m_count--;
        else m_err = 1'b1;
      end

      n_checks++;
      if (tarb_to_tcache_valid !== m_out_valid ||
          (m_out_valid && tarb_to_tcache_data !== m_out_data)) begin
        n_errors++;
        $display("FAIL rand_out[%0d]: valid=%b data=%h expected %b/%h", cyc,
                 tarb_to_tcache_valid, tarb_to_tcache_data, m_out_valid, m_out_data);
      end
      n_checks++;
      if (rays_in_flight !== CntW'(m_count) || err_underflow !== m_err) begin
        n_errors++;
        $display("FAIL rand_cnt[%0d]: count=%0d err=%b expected %0d/%b", cyc, rays_in_flight,
                 err_underflow, m_count, m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_raygen();
    test_round_robin();
    test_ray_limit();
    test_tcache_stall();
    test_admit_retire();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
